// File: rtl/serial_sum_collector_pkg.sv
// rtl/serial_sum_collector_pkg.sv - shared types and constants for the serial sum collector
package serial_sum_collector_pkg;

   localparam int SSC_DEFAULT_WIDTH = 5;

   typedef enum logic [1:0] {
      SSC_IDLE  = 2'd0,
      SSC_SHIFT = 2'd1,
      SSC_HOLD  = 2'd2
   } ssc_state_t;

   // Counter must reach WIDTH after the last shift without wrapping
   function automatic int ssc_cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_sum_collector_bit_counter.sv
// rtl/serial_sum_collector_bit_counter.sv - loadable up-counter with terminal-count flag
module ssc_bit_counter #(
   parameter int CW = 3,
   parameter int TC = 4
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (inc) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == CW'(TC));

endmodule

// File: rtl/serial_sum_collector.sv
// rtl/serial_sum_collector.sv - assembles a bit-serial sum and carry into a parallel word
// with a valid/ready output and a sticky flag for dropped start pulses.
module serial_sum_collector
   import serial_sum_collector_pkg::*;
#(
   parameter int WIDTH = SSC_DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sum_bit,
   input  logic             carry_in,
   input  logic             out_ready,
   input  logic             err_clr,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             out_valid,
   output logic             busy,
   output logic             err_overrun
);

   localparam int CW = ssc_cnt_width(WIDTH);

   ssc_state_t       state_q, state_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             valid_q, busy_q;
   logic             err_q, err_d;

   logic             cnt_load, cnt_inc, cnt_tc;
   logic [CW-1:0]    cnt_q;
   logic             capture, finish, err_set;

   ssc_bit_counter #(
      .CW (CW),
      .TC (WIDTH - 1)
   ) u_bit_counter (
      .clock    (clock),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (CW'(1)),
      .inc      (cnt_inc),
      .cnt      (cnt_q),
      .tc       (cnt_tc)
   );

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      capture  = 1'b0;
      finish   = 1'b0;
      err_set  = 1'b0;

      case (state_q)
         SSC_IDLE: begin
            capture = start;
         end
         SSC_SHIFT: begin
            for (int i = 1; i < WIDTH; i++) begin
               if (cnt_q == CW'(i)) begin
                  shadow_d[i] = sum_bit;
               end
            end
            cnt_inc = 1'b1;
            err_set = start;
            finish  = cnt_tc;
         end
         SSC_HOLD: begin
            if (out_ready) begin
               if (start) begin
                  capture = 1'b1;
               end else begin
                  state_d = SSC_IDLE;
               end
            end else begin
               err_set = start;
            end
         end
         default: begin
            state_d = SSC_IDLE;
         end
      endcase

      // A one-bit frame completes in its own start cycle
      if (capture) begin
         shadow_d[0] = sum_bit;
         cnt_load    = 1'b1;
         if (WIDTH == 1) begin
            finish = 1'b1;
         end else begin
            state_d = SSC_SHIFT;
         end
      end

      if (finish) begin
         sum_d   = shadow_d;
         carry_d = carry_in;
         state_d = SSC_HOLD;
      end

      err_d = err_q;
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SSC_IDLE;
         shadow_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         valid_q  <= (state_d == SSC_HOLD);
         busy_q   <= (state_d == SSC_SHIFT);
         err_q    <= err_d;
      end
   end

   assign sum_out     = sum_q;
   assign carry_out   = carry_q;
   assign out_valid   = valid_q;
   assign busy        = busy_q;
   assign err_overrun = err_q;

endmodule

// File: tb/tb_serial_sum_collector.sv
// tb/tb_serial_sum_collector.sv - directed bench for serial_sum_collector (WIDTH 5 and 1)
module tb_serial_sum_collector;

   logic       clock = 1'b0;
   logic       rst_n;
   logic       start, sum_bit, carry_in, out_ready, err_clr;
   logic [4:0] sum_out;
   logic       carry_out, out_valid, busy, err_overrun;

   logic       start1, sum_bit1, carry_in1, out_ready1, err_clr1;
   logic [0:0] sum_out1;
   logic       carry_out1, out_valid1, busy1, err_overrun1;
   logic       busy1_seen = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   always @(negedge clock) if (busy1 === 1'b1) busy1_seen <= 1'b1;

   serial_sum_collector #(.WIDTH(5)) dut5 (
      .clock(clock), .rst_n(rst_n), .start(start), .sum_bit(sum_bit),
      .carry_in(carry_in), .out_ready(out_ready), .err_clr(err_clr),
      .sum_out(sum_out), .carry_out(carry_out), .out_valid(out_valid),
      .busy(busy), .err_overrun(err_overrun)
   );

   serial_sum_collector #(.WIDTH(1)) dut1 (
      .clock(clock), .rst_n(rst_n), .start(start1), .sum_bit(sum_bit1),
      .carry_in(carry_in1), .out_ready(out_ready1), .err_clr(err_clr1),
      .sum_out(sum_out1), .carry_out(carry_out1), .out_valid(out_valid1),
      .busy(busy1), .err_overrun(err_overrun1)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Drives one 5-bit frame; carry_in is inverted on non-final bits so a wrong sample shows
   task automatic drive_bits(input logic [4:0] bits, input logic carry, input int extra_at,
                             input logic clr_at_extra);
      for (int i = 0; i < 5; i++) begin
         start    = (i == 0) || (i == extra_at);
         sum_bit  = bits[i];
         carry_in = (i == 4) ? carry : ~carry;
         err_clr  = clr_at_extra && (i == extra_at);
         tick();
      end
      start   = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 0; sum_bit = 0; carry_in = 0; out_ready = 0; err_clr = 0;
      start1 = 0; sum_bit1 = 0; carry_in1 = 0; out_ready1 = 0; err_clr1 = 0;
      tick(); tick();
      vectors++;
      if ({sum_out, carry_out, out_valid, busy, err_overrun} !== 9'h000) begin
         miscompares++;
         $display("FAIL reset_w5: got %h expected %h",
                  {sum_out, carry_out, out_valid, busy, err_overrun}, 9'h000);
      end
      vectors++;
      if ({sum_out1, carry_out1, out_valid1, busy1, err_overrun1} !== 5'h00) begin
         miscompares++;
         $display("FAIL reset_w1: got %h expected %h",
                  {sum_out1, carry_out1, out_valid1, busy1, err_overrun1}, 5'h00);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_frame;
      logic [4:0] bits;
      bits = 5'b10110;
      for (int i = 0; i < 5; i++) begin
         start    = (i == 0);
         sum_bit  = bits[i];
         carry_in = (i == 4);
         tick();
         if (i < 4) begin
            vectors++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL single_busy t+%0d: got busy=%b valid=%b expected busy=1 valid=0",
                        i + 1, busy, out_valid);
            end
         end
      end
      start = 1'b0;
      vectors++;
      if ({out_valid, busy, sum_out, carry_out} !== {1'b1, 1'b0, 5'h16, 1'b1}) begin
         miscompares++;
         $display("FAIL single_result: got valid=%b busy=%b sum=%h carry=%b expected 1 0 16 1",
                  out_valid, busy, sum_out, carry_out);
      end
   endtask

   task automatic test_stall;
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || sum_out !== 5'h16 || carry_out !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_hold %0d: got valid=%b sum=%h carry=%b expected 1 16 1",
                     i, out_valid, sum_out, carry_out);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_release: got valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      drive_bits(5'b10110, 1'b1, -1, 1'b0);
      out_ready = 1'b1; start = 1'b1; sum_bit = 1'b1; carry_in = 1'b1;
      tick();
      out_ready = 1'b0; start = 1'b0;
      vectors++;
      if ({out_valid, busy, sum_out} !== {1'b0, 1'b1, 5'h16}) begin
         miscompares++;
         $display("FAIL b2b_no_bubble: got valid=%b busy=%b sum=%h expected 0 1 16",
                  out_valid, busy, sum_out);
      end
      for (int i = 1; i < 5; i++) begin
         sum_bit  = 1'b1;
         carry_in = (i != 4);
         tick();
      end
      vectors++;
      if ({out_valid, sum_out, carry_out} !== {1'b1, 5'h1F, 1'b0}) begin
         miscompares++;
         $display("FAIL b2b_second: got valid=%b sum=%h carry=%b expected 1 1f 0",
                  out_valid, sum_out, carry_out);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_overrun;
      drive_bits(5'b01011, 1'b0, 2, 1'b0);
      vectors++;
      if ({out_valid, sum_out, carry_out, err_overrun} !== {1'b1, 5'h0B, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL overrun_shift: got valid=%b sum=%h carry=%b err=%b expected 1 0b 0 1",
                  out_valid, sum_out, carry_out, err_overrun);
      end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      vectors++;
      if (err_overrun !== 1'b0 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL overrun_clr: got err=%b valid=%b expected 0 1", err_overrun, out_valid);
      end
      start = 1'b1; out_ready = 1'b0; tick(); start = 1'b0;
      vectors++;
      if ({err_overrun, out_valid, busy, sum_out} !== {1'b1, 1'b1, 1'b0, 5'h0B}) begin
         miscompares++;
         $display("FAIL overrun_hold: got err=%b valid=%b busy=%b sum=%h expected 1 1 0 0b",
                  err_overrun, out_valid, busy, sum_out);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      drive_bits(5'b00100, 1'b1, 1, 1'b1);
      vectors++;
      if ({err_overrun, sum_out, carry_out} !== {1'b1, 5'h04, 1'b1}) begin
         miscompares++;
         $display("FAIL overrun_set_wins: got err=%b sum=%h carry=%b expected 1 04 1",
                  err_overrun, sum_out, carry_out);
      end
   endtask

   task automatic test_reset_mid_frame;
      out_ready = 1'b1; start = 1'b1; sum_bit = 1'b1;
      tick();
      out_ready = 1'b0; start = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({sum_out, carry_out, out_valid, busy, err_overrun} !== 9'h000) begin
         miscompares++;
         $display("FAIL midframe_reset: got %h expected %h",
                  {sum_out, carry_out, out_valid, busy, err_overrun}, 9'h000);
      end
      tick();
      rst_n = 1'b1;
      tick();
      drive_bits(5'b11001, 1'b1, -1, 1'b0);
      vectors++;
      if ({out_valid, sum_out, carry_out, err_overrun} !== {1'b1, 5'h19, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL midframe_after: got valid=%b sum=%h carry=%b err=%b expected 1 19 1 0",
                  out_valid, sum_out, carry_out, err_overrun);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_width1;
      start1 = 1'b1; sum_bit1 = 1'b1; carry_in1 = 1'b1;
      tick();
      start1 = 1'b0; sum_bit1 = 1'b0; carry_in1 = 1'b0;
      vectors++;
      if ({out_valid1, sum_out1, carry_out1, busy1} !== 4'b1110) begin
         miscompares++;
         $display("FAIL w1_frame: got %b expected 1110", {out_valid1, sum_out1, carry_out1, busy1});
      end
      out_ready1 = 1'b1; start1 = 1'b1; sum_bit1 = 1'b0; carry_in1 = 1'b0;
      tick();
      start1 = 1'b0;
      vectors++;
      if ({out_valid1, sum_out1, carry_out1} !== 3'b100) begin
         miscompares++;
         $display("FAIL w1_b2b: got %b expected 100", {out_valid1, sum_out1, carry_out1});
      end
      tick();
      out_ready1 = 1'b0;
      vectors++;
      if (out_valid1 !== 1'b0) begin
         miscompares++;
         $display("FAIL w1_drain: got valid=%b expected 0", out_valid1);
      end
      vectors++;
      if (busy1_seen !== 1'b0) begin
         miscompares++;
         $display("FAIL w1_busy: got busy_seen=%b expected 0", busy1_seen);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_stall();
      test_back_to_back();
      test_overrun();
      test_reset_mid_frame();
      test_width1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_sum_collector.md
# serial_sum_collector

Downstream stage of the synchronous serial adder. Collects the bit-serial sum stream (LSB first) and the final carry, and assembles them into a parallel word. Presents the result on a valid/ready handshake to the consuming logic. The result stays held while the consumer stalls, and start pulses that arrive at a bad time are flagged.

## Interface
- `WIDTH`, default 5: number of sum bits per frame, equal to the adder shift-register depth. Legal range is 1..32.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  marks the first (LSB) sum bit, present on `sum_bit` in the same cycle.
- `sum_bit`  in  1  serial sum bit from the adder, one bit per cycle, LSB first.
- `carry_in`  in  1  final adder carry, sampled only in the cycle carrying bit `WIDTH-1`.
- `out_ready`  in  1  the consumer accepts the result when `out_valid` is also high.
- `err_clr`  in  1  synchronous clear of `err_overrun`.
- `sum_out`  out  WIDTH  assembled sum.
- `carry_out`  out  1  captured final carry.
- `out_valid`  out  1  `sum_out`/`carry_out` hold a complete, unaccepted result.
- `busy`  out  1  a frame is being shifted in (state SHIFT).
- `err_overrun`  out  1  sticky flag: a start pulse was dropped.

## Operation
- FSM states are IDLE, SHIFT and HOLD.
- IDLE:
  - On `start`, write `sum_bit` into shadow bit 0 and set `cnt`=1.
  - Go to SHIFT, or straight to HOLD when `WIDTH`=1.
- SHIFT, each cycle:
  - Write `sum_bit` into shadow bit `cnt` and increment `cnt`.
  - When `cnt`==`WIDTH-1`, write the last bit, copy the shadow register together with `carry_in` into `sum_out`/`carry_out`, and go to HOLD.
- HOLD:
  - `out_valid`=1.
  - On `out_ready`, go to IDLE.
  - On `out_ready`&`start` in the same cycle, accept the new frame (capture bit 0, go to SHIFT). Back-to-back frames therefore cost no bubble.
- Dropped starts:
  - `start` in SHIFT is ignored: the frame continues and `err_overrun` is set.
  - `start` in HOLD without `out_ready` is ignored and `err_overrun` is set.
- `err_clr` clears `err_overrun`. If a set and `err_clr` occur in the same cycle, the set wins.
- `sum_out`/`carry_out` change only on the SHIFT→HOLD (or IDLE→HOLD) transition. They are stable for the whole time `out_valid` is high.
- `sum_bit` and `carry_in` are don't-care outside capture cycles.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State=IDLE, `cnt`=0, shadow register=0.
  - `sum_out`=0, `carry_out`=0, `out_valid`=0, `busy`=0, `err_overrun`=0.
- Reset mid-frame discards partial data. The first frame after reset needs a fresh `start`.
- Latency: `start` in cycle t, last bit in t+`WIDTH`-1, `out_valid` high from t+`WIDTH`.
- `busy` is high from t+1 to t+`WIDTH`-1 and is never high when `WIDTH`=1.
- Handshake: the transfer occurs in the cycle where `out_valid`&`out_ready` are both high. `out_valid` falls in the next cycle unless a new frame completes.
- `out_valid` never depends combinationally on `out_ready`. All outputs are registered.
- `cnt` width is clog2(`WIDTH`+1). No wrap-around is reachable, because SHIFT exits at `WIDTH-1`.

## Structure
- Shared package contents:
  - state enum `ssc_state_t` (IDLE, SHIFT, HOLD).
  - constant `SSC_DEFAULT_WIDTH`=5, matching the adder depth.
- One sub-module, `ssc_bit_counter`: a loadable up-counter with terminal-count output, used for `cnt`.
- The FSM, shadow register and output register live in the top module.

## Test plan
- Single frame, `WIDTH`=5: `start` with bits 0,1,1,0,1 LSB first and `carry_in`=1 on the last bit → `out_valid`=1 at t+5, `sum_out`=5'b10110 (0x16), `carry_out`=1.
- Consumer stall: `out_ready` held low for 10 cycles after completion → `sum_out`=0x16 stable throughout. `out_ready`=1 → `out_valid`=0 next cycle.
- Back-to-back frames: `out_ready`&`start` in the same HOLD cycle, second frame all ones with `carry_in`=0 → second result 0x1F and `carry_out`=0 at 5 cycles after the second start. There is no idle cycle between frames.
- Overrun:
  - `start` at t+2 during SHIFT → the frame completes with the original data and `err_overrun`=1.
  - `err_clr` pulse → `err_overrun`=0.
  - `err_clr` coinciding with a new overrun → `err_overrun` stays 1.
- Reset mid-frame: `rst_n` low at t+3 → all outputs 0 immediately. A new frame after release yields the correct value.
- `WIDTH`=1: `start` with `sum_bit`=1 and `carry_in`=1 → `out_valid` at t+1, `sum_out`=1, `carry_out`=1, `busy` never asserted.
